// File: rtl/led_pwm_fader_pkg.sv
// Shared constants and step helper for the LED PWM fader.
package led_pkg;

   localparam int unsigned NUM_LEDS                = 4;
   localparam int unsigned DEF_PWM_WIDTH           = 8;
   localparam int unsigned DEF_FADE_PRESCALE_WIDTH = 16;

   // Direction of a single fade step for one channel.
   typedef enum logic [1:0] {
      STEP_HOLD = 2'd0,
      STEP_UP   = 2'd1,
      STEP_DOWN = 2'd2
   } step_e;

   // Which way a level must move to approach its target.
   function automatic step_e step_dir(input int unsigned level, input int unsigned target);
      if (level < target) begin
         return STEP_UP;
      end else if (level > target) begin
         return STEP_DOWN;
      end
      return STEP_HOLD;
   endfunction

endpackage

// File: rtl/led_pwm_fader_if.sv
// Pattern-side inputs and LED-side outputs of the fader.
interface led_pwm_fader_if #(
   parameter int unsigned PWM_WIDTH = led_pkg::DEF_PWM_WIDTH
);
   logic [led_pkg::NUM_LEDS-1:0] PATTERN;
   logic [PWM_WIDTH-1:0]         BRIGHTNESS;
   logic                         ENABLE;
   logic [led_pkg::NUM_LEDS-1:0] LEDS;
   logic                         FADING;

   modport master (
      output PATTERN, BRIGHTNESS, ENABLE,
      input  LEDS, FADING
   );

   modport slave (
      input  PATTERN, BRIGHTNESS, ENABLE,
      output LEDS, FADING
   );
endinterface

// File: rtl/led_pwm_fader_channel.sv
// One LED: level ramps toward target on fade ticks, duty latches the level
// at each PWM period boundary, LED output is the registered PWM compare.
module led_fade_channel
   import led_pkg::*;
#(
   parameter int unsigned PWM_WIDTH = DEF_PWM_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [PWM_WIDTH-1:0] pwm_cnt_i,
   input  logic                 fade_tick_i,
   input  logic                 period_end_i,
   input  logic [PWM_WIDTH-1:0] target_i,
   input  logic                 enable_i,
   output logic                 led_o,
   output logic                 fading_o
);

   logic [PWM_WIDTH-1:0] level_q, level_d;
   logic [PWM_WIDTH-1:0] duty_q, duty_d;
   logic                 led_q, led_d;
   step_e                step;

   // Next level, next duty and next LED drive, all from pre-edge state.
   always_comb begin
      step    = step_dir(32'(level_q), 32'(target_i));
      level_d = level_q;
      if (fade_tick_i) begin
         unique case (step)
            STEP_UP:   level_d = level_q + PWM_WIDTH'(1);
            STEP_DOWN: level_d = level_q - PWM_WIDTH'(1);
            default:   level_d = level_q;
         endcase
      end
      duty_d = period_end_i ? level_q : duty_q;
      led_d  = enable_i & (pwm_cnt_i < duty_q);
   end

   // Channel state registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         level_q <= '0;
         duty_q  <= '0;
         led_q   <= 1'b0;
      end else begin
         level_q <= level_d;
         duty_q  <= duty_d;
         led_q   <= led_d;
      end
   end

   assign led_o    = led_q;
   assign fading_o = (level_q != target_i);

endmodule

// File: rtl/led_pwm_fader.sv
// PWM LED output stage: shared counters, pattern/brightness capture, and
// one fade channel per LED.
module led_pwm_fader
   import led_pkg::*;
#(
   parameter int unsigned PWM_WIDTH           = DEF_PWM_WIDTH,
   parameter int unsigned FADE_PRESCALE_WIDTH = DEF_FADE_PRESCALE_WIDTH
) (
   input  logic            CLK,
   input  logic            RSTN,
   led_pwm_fader_if.slave  bus
);

   logic [PWM_WIDTH-1:0]           pwm_cnt_q;
   logic [FADE_PRESCALE_WIDTH-1:0] fade_cnt_q;
   logic [NUM_LEDS-1:0]            pattern_q;
   logic [PWM_WIDTH-1:0]           brightness_q, brightness_d;
   logic                           fading_q, fading_d;

   logic                           fade_tick;
   logic                           period_end;
   logic [PWM_WIDTH-1:0]           target [NUM_LEDS];
   logic [NUM_LEDS-1:0]            ch_led;
   logic [NUM_LEDS-1:0]            ch_fading;

   assign fade_tick  = &fade_cnt_q;
   assign period_end = &pwm_cnt_q;

   // Per-LED target and the aggregate fading flag.
   always_comb begin
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
         target[i] = pattern_q[i] ? brightness_q : '0;
      end
      brightness_d = period_end ? bus.BRIGHTNESS : brightness_q;
      fading_d     = |ch_fading;
   end

   // Free-running counters, input capture and registered FADING.
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         pwm_cnt_q    <= '0;
         fade_cnt_q   <= '0;
         pattern_q    <= '0;
         brightness_q <= '0;
         fading_q     <= 1'b0;
      end else begin
         pwm_cnt_q    <= pwm_cnt_q + PWM_WIDTH'(1);
         fade_cnt_q   <= fade_cnt_q + FADE_PRESCALE_WIDTH'(1);
         pattern_q    <= bus.PATTERN;
         brightness_q <= brightness_d;
         fading_q     <= fading_d;
      end
   end

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
      led_fade_channel #(
         .PWM_WIDTH (PWM_WIDTH)
      ) u_ch (
         .clk_i        (CLK),
         .rstn_i       (RSTN),
         .pwm_cnt_i    (pwm_cnt_q),
         .fade_tick_i  (fade_tick),
         .period_end_i (period_end),
         .target_i     (target[i]),
         .enable_i     (bus.ENABLE),
         .led_o        (ch_led[i]),
         .fading_o     (ch_fading[i])
      );
   end

   assign bus.LEDS   = ch_led;
   assign bus.FADING = fading_q;

endmodule
